connect4_move_sequencer: RTL

//  Converts raw active-low column buttons (4'b1110=col0 .. 4'b0111=col3) into validated single-move commands for the column-select/gameboard datapath.

---
 rtl/connect4_pkg.sv | 40 ++++
 rtl/connect4_btn_debounce.sv | 55 +++++
 rtl/connect4_move_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/connect4_pkg.sv
// Shared types and helpers for the Connect-4 move sequencer: FSM states,
// game status codes and active-low column decoding.
package connect4_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_RELEASE,
    S_GAME_OVER,
    S_CLEAR
  } state_t;

  localparam logic [1:0] ST_PLAYING = 2'b00;
  localparam logic [1:0] ST_P1_WIN  = 2'b01;
  localparam logic [1:0] ST_P2_WIN  = 2'b10;
  localparam logic [1:0] ST_TIE     = 2'b11;

  localparam logic [3:0] COL_NONE = 4'b1111;

  // Index of the single low bit; multi/no-press patterns map to 0 and are
  // rejected separately by is_single_low.
  function automatic logic [1:0] col_index(input logic [3:0] col_n);
    logic [1:0] idx;
    case (col_n)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic is_single_low(input logic [3:0] col_n);
    return (col_n == 4'b1110) || (col_n == 4'b1101) ||
           (col_n == 4'b1011) || (col_n == 4'b0111);
  endfunction

endpackage

// File: rtl/connect4_btn_debounce.sv
// Two-flop synchroniser plus counter debouncer for one active-low button.
// Produces the debounced level and a one-cycle pulse on an accepted press.
module connect4_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic level_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Level flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      level_d = sync2_q;
      cnt_d   = '0;
      press_d = ~sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_n = level_q;
  assign press   = press_q;

endmodule

// File: rtl/connect4_move_sequencer.sv
// Turns debounced column/new-game buttons into validated single-move strobes
// for the gameboard datapath, tracking turn, ack timeout and game clears.
module connect4_move_sequencer
  import connect4_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ROWS            = 4,
  parameter int ACK_TIMEOUT     = 8,
  parameter int CLEAR_CYCLES    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  btn_column,
  input  logic        btn_new_game,
  input  logic [1:0]  game_status,
  input  logic [11:0] col_count,
  output logic        move_enable,
  output logic [3:0]  move_column,
  output logic        clear_game,
  output logic        player_turn,
  output logic        move_reject,
  output logic        ack_fault
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int KW = $clog2(CLEAR_CYCLES + 1);

  logic [3:0] col_db, col_press;
  logic       ng_level, ng_press;

  for (genvar i = 0; i < 4; i++) begin : g_col_db
    connect4_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_col_db (
      .clk    (clk),
      .reset  (reset),
      .btn_n  (btn_column[i]),
      .level_n(col_db[i]),
      .press  (col_press[i])
    );
  end

  connect4_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_new_game_db (
    .clk    (clk),
    .reset  (reset),
    .btn_n  (btn_new_game),
    .level_n(ng_level),
    .press  (ng_press)
  );

  state_t        state_q, state_d;
  logic [3:0]    pat_q, pat_d;
  logic [2:0]    snap_q, snap_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [KW-1:0] clr_cnt_q, clr_cnt_d;
  logic          move_enable_q, move_enable_d;
  logic [3:0]    move_column_q, move_column_d;
  logic          clear_game_q, clear_game_d;
  logic          player_turn_q, player_turn_d;
  logic          move_reject_q, move_reject_d;
  logic          ack_fault_q, ack_fault_d;
  logic [2:0]    cur_cnt;
  logic          game_active;

  assign game_active = (game_status == ST_PLAYING);

  always_comb begin
    case (col_index(pat_q))
      2'd1:    cur_cnt = col_count[5:3];
      2'd2:    cur_cnt = col_count[8:6];
      2'd3:    cur_cnt = col_count[11:9];
      default: cur_cnt = col_count[2:0];
    endcase
  end

  always_comb begin
    state_d       = state_q;
    pat_d         = pat_q;
    snap_d        = snap_q;
    timer_d       = timer_q;
    clr_cnt_d     = clr_cnt_q;
    move_enable_d = 1'b0;
    move_column_d = COL_NONE;
    clear_game_d  = 1'b0;
    player_turn_d = player_turn_q;
    move_reject_d = 1'b0;
    ack_fault_d   = ack_fault_q;
    case (state_q)
      S_IDLE: begin
        if (col_db != COL_NONE) begin
          pat_d   = col_db;
          state_d = S_CHECK;
        end else if (!game_active) begin
          state_d = S_GAME_OVER;
        end
      end
      S_CHECK: begin
        if (!is_single_low(pat_q) || cur_cnt >= 3'(ROWS) || !game_active) begin
          move_reject_d = 1'b1;
          state_d       = S_WAIT_RELEASE;
        end else begin
          move_enable_d = 1'b1;
          move_column_d = pat_q;
          state_d       = S_ISSUE;
        end
      end
      // Snapshot before the datapath's increment lands at the end of this cycle.
      S_ISSUE: begin
        snap_d  = cur_cnt;
        timer_d = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (cur_cnt == snap_q + 3'd1) begin
          player_turn_d = ~player_turn_q;
          state_d       = S_WAIT_RELEASE;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          ack_fault_d = 1'b1;
          state_d     = S_WAIT_RELEASE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WAIT_RELEASE: begin
        if (col_db == COL_NONE) state_d = game_active ? S_IDLE : S_GAME_OVER;
      end
      S_GAME_OVER: begin
        if (|col_press) move_reject_d = 1'b1;
      end
      S_CLEAR: begin
        if (clr_cnt_q == KW'(CLEAR_CYCLES - 1)) begin
          state_d = S_WAIT_RELEASE;
        end else begin
          clr_cnt_d    = clr_cnt_q + 1'b1;
          clear_game_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // New game overrides everything, including a move about to be issued.
    if (ng_press) begin
      state_d       = S_CLEAR;
      clr_cnt_d     = '0;
      clear_game_d  = 1'b1;
      player_turn_d = 1'b0;
      ack_fault_d   = 1'b0;
      move_enable_d = 1'b0;
      move_column_d = COL_NONE;
      move_reject_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      pat_q         <= COL_NONE;
      snap_q        <= '0;
      timer_q       <= '0;
      clr_cnt_q     <= '0;
      move_enable_q <= 1'b0;
      move_column_q <= COL_NONE;
      clear_game_q  <= 1'b0;
      player_turn_q <= 1'b0;
      move_reject_q <= 1'b0;
      ack_fault_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pat_q         <= pat_d;
      snap_q        <= snap_d;
      timer_q       <= timer_d;
      clr_cnt_q     <= clr_cnt_d;
      move_enable_q <= move_enable_d;
      move_column_q <= move_column_d;
      clear_game_q  <= clear_game_d;
      player_turn_q <= player_turn_d;
      move_reject_q <= move_reject_d;
      ack_fault_q   <= ack_fault_d;
    end
  end

  assign move_enable = move_enable_q;
  assign move_column = move_column_q;
  assign clear_game  = clear_game_q;
  assign player_turn = player_turn_q;
  assign move_reject = move_reject_q;
  assign ack_fault   = ack_fault_q;

endmodule
